// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1/8N2) fed by a circular byte FIFO with req/ack write port.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1/8E2 frames).
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        tx_req_i,
    input  logic [7:0]                  tx_data_bi,
    output logic                        tx_ack_o,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

    localparam int unsigned DIV      = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned LW       = AW + 1;
    localparam int unsigned STOP_CYC = STOP_BITS * DIV;
    localparam int unsigned CW       = $clog2(STOP_CYC + 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [2:0]      bit_q, bit_n;
    logic [7:0]      shift_q, shift_n;
    logic            tx_n;
    logic            busy_n;
    logic [LW-1:0]   level_n;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [7:0]      mem [FIFO_DEPTH];
    logic            full, empty, push, pop;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_n;
`endif

    // Ack reflects the pre-edge full state, so a push racing a pop at full is refused.
    assign full     = (fifo_level_o == LW'(FIFO_DEPTH));
    assign empty    = (fifo_level_o == '0);
    assign tx_ack_o = !full;
    assign push     = tx_req_i && !full;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        tx_n    = tx_o;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif

        case (state_q)
            S_IDLE: begin
                tx_n = 1'b1;
                pop  = !empty;
            end
            S_START: begin
                if (cnt_q == '0) begin
                    state_n = S_DATA;
                    bit_n   = 3'd0;
                    tx_n    = shift_q[0];
                    cnt_n   = CW'(DIV - 1);
                end else begin
                    cnt_n = CW'(cnt_q - 1'b1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = S_PARITY;
                        tx_n    = par_q;
                        cnt_n   = CW'(DIV - 1);
`else
                        state_n = S_STOP;
                        tx_n    = 1'b1;
                        cnt_n   = CW'(STOP_CYC - 1);
`endif
                    end else begin
                        bit_n   = bit_q + 3'd1;
                        shift_n = {1'b0, shift_q[7:1]};
                        tx_n    = shift_q[1];
                        cnt_n   = CW'(DIV - 1);
                    end
                end else begin
                    cnt_n = CW'(cnt_q - 1'b1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == '0) begin
                    state_n = S_STOP;
                    tx_n    = 1'b1;
                    cnt_n   = CW'(STOP_CYC - 1);
                end else begin
                    cnt_n = CW'(cnt_q - 1'b1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == '0) begin
                    state_n = S_IDLE;
                    tx_n    = 1'b1;
                    pop     = !empty;
                end else begin
                    cnt_n = CW'(cnt_q - 1'b1);
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Popping the head always begins a new frame with its start bit.
        if (pop) begin
            shift_n = mem[rd_ptr_q];
            state_n = S_START;
            tx_n    = 1'b0;
            cnt_n   = CW'(DIV - 1);
`ifdef UART_TX_PARITY_EN
            par_n   = ^mem[rd_ptr_q];
`endif
        end

        case ({push, pop})
            2'b10:   level_n = LW'(fifo_level_o + 1'b1);
            2'b01:   level_n = LW'(fifo_level_o - 1'b1);
            default: level_n = fifo_level_o;
        endcase

        busy_n = (state_n != S_IDLE) || (level_n != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            tx_o         <= 1'b1;
            busy_o       <= 1'b0;
            fifo_level_o <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
`ifdef UART_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            bit_q        <= bit_n;
            shift_q      <= shift_n;
            tx_o         <= tx_n;
            busy_o       <= busy_n;
            fifo_level_o <= level_n;
            if (push) wr_ptr_q <= AW'(wr_ptr_q + 1'b1);
            if (pop)  rd_ptr_q <= AW'(rd_ptr_q + 1'b1);
`ifdef UART_TX_PARITY_EN
            par_q        <= par_n;
`endif
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= tx_data_bi;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a line monitor decodes frames.
module tb_uart_tx_fifo;

    localparam int unsigned CLK_HZ = 1000000;
    localparam int unsigned BAUD   = 100000;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned STOPB  = 1;
    localparam int unsigned DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    localparam int unsigned FRAME_BITS = 10 + STOPB - 1 + PAR_BITS;
    localparam int unsigned FRAME_CYC  = FRAME_BITS * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic       tx_o;
    logic       busy;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         starts[$];
    int         peak = 0;

    uart_tx_fifo #(
        .CLK_FREQ_HZ(CLK_HZ),
        .BAUD_RATE  (BAUD),
        .FIFO_DEPTH (DEPTH),
        .STOP_BITS  (STOPB)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tx_req_i    (tx_req),
        .tx_data_bi  (tx_data),
        .tx_ack_o    (tx_ack),
        .tx_o        (tx_o),
        .busy_o      (busy),
        .fifo_level_o(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until ack is seen before an edge; leaves tx_req asserted.
    task automatic send(input logic [7:0] b);
        int   n   = 0;
        logic acc = 1'b0;
        tx_req  = 1'b1;
        tx_data = b;
        while (!acc && n < 500) begin
            acc = tx_ack;
            tick();
            n++;
        end
        check("send_accept", int'(acc), 1);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    always @(negedge clk) begin
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end

    // Line monitor: checks every cycle of each frame and the byte decoded at bit centres.
    int                    ncyc = 0;
    bit                    mon_active = 1'b0;
    bit                    mon_skip;
    bit                    mon_bad;
    int unsigned           mon_cyc;
    int unsigned           bitn;
    logic [7:0]            mon_exp;
    logic [7:0]            mon_dec;
    logic [FRAME_BITS-1:0] mon_bits;

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && tx_o == 1'b0) begin
                mon_active = 1'b1;
                mon_cyc    = 0;
                mon_bad    = 1'b0;
                mon_dec    = '0;
                starts.push_back(ncyc);
                check("frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                mon_skip = (exp_q.size() == 0);
                mon_exp  = mon_skip ? 8'h00 : exp_q.pop_front();
                mon_bits = '1;
                mon_bits[0]   = 1'b0;
                mon_bits[8:1] = mon_exp;
`ifdef UART_TX_PARITY_EN
                mon_bits[9]   = ^mon_exp;
`endif
            end
            if (mon_active) begin
                bitn = mon_cyc / DIV;
                if (tx_o !== mon_bits[bitn[3:0]]) mon_bad = 1'b1;
                if ((mon_cyc % DIV) == DIV / 2 && bitn >= 1 && bitn <= 8)
                    mon_dec = {tx_o, mon_dec[7:1]};
                if (mon_cyc == FRAME_CYC - 1) begin
                    mon_active = 1'b0;
                    if (!mon_skip) begin
                        check("frame_bits", int'(mon_bad), 0);
                        check("frame_byte", int'(mon_dec), int'(mon_exp));
                    end
                end else begin
                    mon_cyc++;
                end
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    task automatic parity_frame(input logic [7:0] b, input int par_exp);
        int n = 0;
        exp_q.push_back(b);
        send(b);
        tx_req = 1'b0;
        repeat (95) tick();
        check("t6_parity_bit", int'(tx_o), par_exp);
        n = 95;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check("t6_frame_len", n - 1, 110);
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int n;
        int lows;

        rst     = 1'b1;
        tx_req  = 1'b0;
        tx_data = 8'h00;
        repeat (3) tick();
        check("rst_tx", int'(tx_o), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_ack", int'(tx_ack), 1);
        rst = 1'b0;
        repeat (2) tick();

        // Single byte: latency and frame length.
        exp_q.push_back(8'h55);
        send(8'h55);
        tx_req  = 1'b0;
        tx_data = 8'hEE;
        check("t1_tx_idle_at_accept", int'(tx_o), 1);
        check("t1_level", int'(fifo_level), 1);
        check("t1_busy", int'(busy), 1);
        tick();
        check("t1_start_latency", int'(tx_o), 0);
        check("t1_level_after_pop", int'(fifo_level), 0);
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check("t1_busy_len", n, FRAME_CYC);
        check("t1_tx_idle", int'(tx_o), 1);
        repeat (5) tick();

        // Back-to-back bytes: contiguous frames.
        peak = 0;
        starts.delete();
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send(8'hA3);
        send(8'h00);
        send(8'hFF);
        tx_req  = 1'b0;
        tx_data = 8'h11;
        wait_idle("t2_idle", 1000);
        check("t2_peak", peak, 2);
        check("t2_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            check("t2_gap0", starts[1] - starts[0], FRAME_CYC);
            check("t2_gap1", starts[2] - starts[1], FRAME_CYC);
        end
        check("t2_queue_empty", exp_q.size(), 0);
        repeat (5) tick();

        // Fill the FIFO while a frame is on the line.
        exp_q.push_back(8'h11);
        send(8'h11);
        tx_req = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            tx_req  = 1'b1;
            tx_data = 8'(8'hB0 + i);
            check($sformatf("t3_ack%0d", i), int'(tx_ack), (i < 4) ? 1 : 0);
            tick();
        end
        tx_req = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hB0 + i));
        check("t3_level_full", int'(fifo_level), 4);

        // Push attempted on the pop edge while full is refused, then accepted.
        repeat (FRAME_CYC - 10) tick();
        check("t4_level_before_pop", int'(fifo_level), 4);
        check("t4_ack_before_pop", int'(tx_ack), 0);
        tx_req  = 1'b1;
        tx_data = 8'h5A;
        tick();
        check("t4_level_after_pop", int'(fifo_level), 3);
        check("t4_ack_after_pop", int'(tx_ack), 1);
        tick();
        check("t4_level_refilled", int'(fifo_level), 4);
        tx_req  = 1'b0;
        tx_data = 8'hEE;
        exp_q.push_back(8'h5A);
        wait_idle("t4_idle", 2000);
        check("t4_queue_empty", exp_q.size(), 0);
        repeat (5) tick();

        // Reset during data bit 3 of the first of three queued bytes.
        exp_q.push_back(8'h3C);
        send(8'h3C);
        send(8'hC3);
        send(8'h96);
        tx_req = 1'b0;
        repeat (43) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_tx", int'(tx_o), 1);
        check("t5_level", int'(fifo_level), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_ack", int'(tx_ack), 1);
        lows = 0;
        repeat (300) begin
            tick();
            if (tx_o !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("t5_line_quiet", lows, 0);
        check("t5_queue_empty", exp_q.size(), 0);

`ifdef UART_TX_PARITY_EN
        parity_frame(8'h07, 1);
        repeat (3) tick();
        parity_frame(8'h03, 0);
        repeat (3) tick();
        check("t6_queue_empty", exp_q.size(), 0);
`endif

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte-oriented UART transmitter with an input FIFO. It serialises bytes onto the board UART line and is the transmit end of the same 8N1 link whose receive side is fed from the board's UART input. It sits between the SoC debug/peripheral fabric (req/ack byte writes) and the tx pin. It is also instantiated in board-level benches to drive stimulus into the SoC rx_i.

Parameters:
CLK_FREQ_HZ, 100000000, input clock frequency in Hz
BAUD_RATE, 115200, line rate; bit period DIV = CLK_FREQ_HZ / BAUD_RATE (integer truncation, must be >= 2)
FIFO_DEPTH, 16, input FIFO entries; power of two, >= 2
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
tx_req_i  input  1  write request for one byte
tx_data_bi  input  8  byte to transmit, sampled when tx_req_i && tx_ack_o
tx_ack_o  output  1  FIFO not full; byte accepted on any edge where tx_req_i && tx_ack_o
tx_o  output  1  serial line, idle high, registered
busy_o  output  1  high while a frame is on the line or the FIFO is non-empty
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset, clk_i edge with rst_i=1: tx_o=1, busy_o=0, fifo_level_o=0, tx_ack_o=1, FSM=IDLE, FIFO pointers cleared, baud and bit counters cleared. Reset mid-frame aborts the frame; tx_o is high from the cycle after the reset edge, and queued bytes are discarded.
- FIFO: circular buffer with wrap-around read/write pointers. Push on tx_req_i && !full; pop only by the FSM. tx_ack_o = !full, combinational from registered state.
- Simultaneous push and pop: level unchanged, and both take effect. When full, a push in the same cycle as a pop is still refused, because ack reflects the pre-edge full state.
- Requests while full are dropped with no side effects. The requester must hold tx_req_i until ack.
- FSM states:
  - IDLE: tx_o=1. If the FIFO is non-empty, pop the head into the shift register, go to START, and load the baud counter with DIV-1.
  - START: tx_o=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0] for DIV cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP (or to PARITY when that feature is enabled).
  - STOP: tx_o=1 for STOP_BITS*DIV cycles. On the last cycle: if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter: down-counter reloaded with DIV-1 at each bit boundary. A bit ends when the counter reaches 0.
- Latency: byte accepted at edge N into an empty FIFO with FSM in IDLE → popped at edge N+1 → tx_o low from edge N+1. The first start-bit cycle is the cycle after the accept cycle.
- Frame length: (10 + STOP_BITS - 1) * DIV cycles, or one more DIV with parity enabled.
- busy_o = (FSM != IDLE) || (fifo_level_o != 0), registered-equivalent: it updates on the same edge as state and level.
- Changes to tx_data_bi after acceptance do not affect the transmitted byte.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for DIV cycles, giving an 8E1 (or 8E2) frame.
- Undefined: no PARITY state and no parity logic; the frame is 8N1/8N2 exactly as in Behaviour.

Test Plan:
1. CLK_FREQ_HZ=1000000, BAUD_RATE=100000 (DIV=10). Write 0x55 once → tx_o low 1 cycle after accept for 10 cycles, then bits 1,0,1,0,1,0,1,0 at 10 cycles each, then high. busy_o falls exactly 100 cycles after tx_o first goes low.
2. Write 0xA3, 0x00, 0xFF back-to-back → three contiguous 100-cycle frames with no idle cycles between stop and next start. The decoded bytes match, and fifo_level_o peaks at 2.
3. FIFO_DEPTH=4: hold tx_req_i for 8 cycles with distinct bytes while a frame is in progress. tx_ack_o drops after 4 accepts, only the accepted bytes are transmitted, and they go out in order.
4. At a full FIFO, assert tx_req_i on the cycle the FSM pops → push refused, fifo_level_o goes 4→3, and the byte is accepted on the following cycle.
5. Assert rst_i for 1 cycle during DATA bit 3 of the first of 3 queued bytes → tx_o=1 the next cycle, fifo_level_o=0, busy_o=0, and nothing further is transmitted.
6. With UART_TX_PARITY_EN defined, write 0x07 → parity bit 1 after the data bits, frame length 110 cycles. Write 0x03 → parity bit 0.
